// File: rtl/intc_pkg.sv
// Shared types and constants for the intr_ctrl interrupt controller.
package intc_pkg;

  localparam int unsigned ID_W   = 5;
  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] REG_PEND = 2'd0;
  localparam logic [1:0] REG_MASK = 2'd1;
  localparam logic [1:0] REG_VEC  = 2'd2;
  localparam logic [1:0] REG_EOI  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  // Read layout of the VEC register.
  typedef struct packed {
    logic              in_service;
    logic [25:0]       rsvd;
    logic [ID_W-1:0]   id;
  } vec_t;

endpackage

// File: rtl/prio_enc.sv
// Lowest-index-first priority encoder: valid plus ID of the lowest set request bit.
module prio_enc
  import intc_pkg::*;
#(
  parameter int unsigned NUM_SRC = 8
) (
  input  logic [NUM_SRC-1:0] req,
  output logic               valid,
  output logic [ID_W-1:0]    id
);

  // Scan from the top down so the lowest set bit is written last and wins.
  always_comb begin
    valid = |req;
    id    = '0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (req[i]) id = ID_W'(i);
    end
  end

endmodule

// File: rtl/intr_ctrl.sv
// Prioritised interrupt controller with pending/mask/vector/EOI registers on the CPU IO bus.
// Optional macro INTC_SYNC_EN adds a two-flop synchronizer on irq_in before edge detection.
module intr_ctrl
  import intc_pkg::*;
#(
  parameter int unsigned NUM_SRC   = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0100
) (
  input  logic                sys_clk,
  input  logic                reset,
  input  logic [NUM_SRC-1:0]  irq_in,
  input  logic                io_cs,
  input  logic                io_rd,
  input  logic                io_wr,
  input  logic [DATA_W-1:0]   io_addr,
  input  logic [DATA_W-1:0]   io_din,
  output logic [DATA_W-1:0]   io_dout,
  output logic                INTR,
  input  logic                INT_ACK
);

  state_t               state;
  logic [NUM_SRC-1:0]   irq_s;
  logic [NUM_SRC-1:0]   irq_prev;
  logic [NUM_SRC-1:0]   irq_rise;
  logic [NUM_SRC-1:0]   pend;
  logic [NUM_SRC-1:0]   mask;
  logic [NUM_SRC-1:0]   cand;
  logic [NUM_SRC-1:0]   w1c;
  logic [NUM_SRC-1:0]   ack_clr;
  logic [ID_W-1:0]      vec_id;
  logic [ID_W-1:0]      win_id;
  logic                 cand_valid;
  logic                 in_service;
  logic                 hit;
  logic [1:0]           reg_idx;
  logic                 wr_pend;
  logic                 wr_mask;
  logic                 wr_eoi;
  logic                 rd_en;
  vec_t                 vec_rd;
  logic                 unused_bits;

`ifdef INTC_SYNC_EN
  logic [NUM_SRC-1:0]   sync_q1;
  logic [NUM_SRC-1:0]   sync_q2;

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= irq_in;
      sync_q2 <= sync_q1;
    end
  end

  assign irq_s = sync_q2;
`else
  assign irq_s = irq_in;
`endif

  // Address decode: 16-byte window, word-spaced registers.
  assign hit     = io_cs && (io_addr[31:4] == BASE_ADDR[31:4]);
  assign reg_idx = io_addr[3:2];
  assign wr_pend = hit && io_wr && (reg_idx == REG_PEND);
  assign wr_mask = hit && io_wr && (reg_idx == REG_MASK);
  assign wr_eoi  = hit && io_wr && (reg_idx == REG_EOI);
  assign rd_en   = hit && io_rd;

  assign unused_bits = ^{io_addr[1:0], io_din};

  assign irq_rise = irq_s & ~irq_prev;
  assign cand     = pend & ~mask;
  assign w1c      = wr_pend ? io_din[NUM_SRC-1:0] : '0;

  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      ack_clr[i] = (state == ST_REQ) && INT_ACK && (vec_id == ID_W'(i));
    end
  end

  prio_enc #(
    .NUM_SRC (NUM_SRC)
  ) u_prio_enc (
    .req   (cand),
    .valid (cand_valid),
    .id    (win_id)
  );

  // Register file and request/service state machine; a new edge beats any clear.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      INTR       <= 1'b0;
      pend       <= '0;
      mask       <= '1;
      in_service <= 1'b0;
      vec_id     <= '0;
      irq_prev   <= '0;
    end else begin
      irq_prev <= irq_s;
      pend     <= (pend & ~w1c & ~ack_clr) | irq_rise;
      if (wr_mask) mask <= io_din[NUM_SRC-1:0];

      case (state)
        ST_IDLE: begin
          if (cand_valid) begin
            vec_id <= win_id;
            INTR   <= 1'b1;
            state  <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (INT_ACK) begin
            in_service <= 1'b1;
            INTR       <= 1'b0;
            state      <= ST_SERVICE;
          end
        end
        ST_SERVICE: begin
          if (wr_eoi) begin
            in_service <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: begin
          INTR  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign vec_rd = '{in_service: in_service, rsvd: '0, id: vec_id};

  // Combinational read mux; forced to zero while reset is held.
  always_comb begin
    io_dout = '0;
    if (!reset && rd_en) begin
      case (reg_idx)
        REG_PEND: io_dout = DATA_W'(pend);
        REG_MASK: io_dout = DATA_W'(mask);
        REG_VEC:  io_dout = vec_rd;
        default:  io_dout = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_intr_ctrl.sv
// Scoreboard bench for intr_ctrl: stimulus queues expected reads/INTR samples, a monitor compares.
module tb_intr_ctrl;

  localparam int unsigned NUM_SRC = 8;
  localparam logic [31:0] BASE    = 32'h0000_0100;
`ifdef INTC_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif

  localparam logic [3:0] OFF_P = 4'h0;
  localparam logic [3:0] OFF_M = 4'h4;
  localparam logic [3:0] OFF_V = 4'h8;
  localparam logic [3:0] OFF_E = 4'hC;

  logic                sys_clk;
  logic                reset;
  logic [NUM_SRC-1:0]  irq_in;
  logic                io_cs;
  logic                io_rd;
  logic                io_wr;
  logic [31:0]         io_addr;
  logic [31:0]         io_din;
  logic [31:0]         io_dout;
  logic                INTR;
  logic                INT_ACK;

  int                  checks;
  int                  failures;
  logic [31:0]         exp_q[$];
  bit                  kind_q[$];
  string               name_q[$];
  logic                intr_chk;
  logic                done;
  logic                done_seen;

  intr_ctrl #(
    .NUM_SRC   (NUM_SRC),
    .BASE_ADDR (BASE)
  ) dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .irq_in  (irq_in),
    .io_cs   (io_cs),
    .io_rd   (io_rd),
    .io_wr   (io_wr),
    .io_addr (io_addr),
    .io_din  (io_din),
    .io_dout (io_dout),
    .INTR    (INTR),
    .INT_ACK (INT_ACK)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Monitor: pops one expectation whenever a read or an INTR sample is presented.
  always @(negedge sys_clk) begin
    logic [31:0] e;
    logic [31:0] act;
    bit          k;
    string       n;
    if ((io_cs && io_rd) || intr_chk) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_underflow: no expectation queued at %0t", $time);
      end else begin
        e   = exp_q.pop_front();
        k   = kind_q.pop_front();
        n   = name_q.pop_front();
        act = k ? {31'b0, INTR} : io_dout;
        if (act !== e) begin
          failures++;
          $display("FAIL %s: got 0x%08h expected 0x%08h", n, act, e);
        end
      end
    end
    if (done && !done_seen) begin
      done_seen = 1'b1;
      checks++;
      if (exp_q.size() != 0) begin
        failures++;
        $display("FAIL scoreboard_leftover: got %0d expected 0", exp_q.size());
      end
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] off, input logic [31:0] d);
    io_cs   = 1'b1;
    io_wr   = 1'b1;
    io_addr = BASE + 32'(off);
    io_din  = d;
    tick();
    io_cs   = 1'b0;
    io_wr   = 1'b0;
    io_din  = '0;
  endtask

  task automatic rd_a(input logic [31:0] a, input logic [31:0] e, input string n);
    io_cs   = 1'b1;
    io_rd   = 1'b1;
    io_addr = a;
    exp_q.push_back(e);
    kind_q.push_back(1'b0);
    name_q.push_back(n);
    tick();
    io_cs   = 1'b0;
    io_rd   = 1'b0;
  endtask

  task automatic rd(input logic [3:0] off, input logic [31:0] e, input string n);
    rd_a(BASE + 32'(off), e, n);
  endtask

  task automatic chk_intr(input logic e, input string n);
    intr_chk = 1'b1;
    exp_q.push_back({31'b0, e});
    kind_q.push_back(1'b1);
    name_q.push_back(n);
    tick();
    intr_chk = 1'b0;
  endtask

  task automatic ack();
    INT_ACK = 1'b1;
    tick();
    INT_ACK = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1);
  end

  initial begin
    checks    = 0;
    failures  = 0;
    intr_chk  = 1'b0;
    done      = 1'b0;
    done_seen = 1'b0;
    reset     = 1'b1;
    irq_in    = '0;
    io_cs     = 1'b0;
    io_rd     = 1'b0;
    io_wr     = 1'b0;
    io_addr   = '0;
    io_din    = '0;
    INT_ACK   = 1'b0;
    repeat (3) tick();
    reset = 1'b0;

    rd(OFF_P, 32'h0, "rst_pend");
    rd(OFF_M, 32'hFF, "rst_mask");
    rd(OFF_V, 32'h0, "rst_vec");
    chk_intr(1'b0, "rst_intr");

    // Single unmasked source: INTR one cycle after pend sets.
    wr(OFF_M, 32'hFE);
    irq_in[0] = 1'b1;
    tick();
    repeat (SL) tick();
    chk_intr(1'b0, "t1_intr_pre");
    chk_intr(1'b1, "t1_intr_raise");
    rd(OFF_P, 32'h01, "t1_pend");
    irq_in[0] = 1'b0;
    ack();
    chk_intr(1'b0, "t1_intr_ack");
    rd(OFF_V, 32'h8000_0000, "t1_vec");
    rd(OFF_P, 32'h0, "t1_pend_clr");
    rd_a(32'h0000_0200, 32'h0, "miss_read");
    rd(OFF_E, 32'h0, "eoi_read");
    wr(OFF_E, 32'h0);

    // Two simultaneous sources: lowest index first, other re-raised after EOI.
    wr(OFF_M, 32'h0);
    irq_in = 8'h28;
    tick();
    repeat (SL) tick();
    rd(OFF_P, 32'h28, "t2_pend");
    rd(OFF_V, 32'h0000_0003, "t2_vec_req");
    chk_intr(1'b1, "t2_intr");
    irq_in = '0;
    ack();
    rd(OFF_P, 32'h20, "t2_pend_ack");
    rd(OFF_V, 32'h8000_0003, "t2_vec3");
    chk_intr(1'b0, "t2_intr_svc");
    wr(OFF_E, 32'h0);
    chk_intr(1'b0, "t2_intr_eoi");
    chk_intr(1'b1, "t2_reraise");
    ack();
    rd(OFF_V, 32'h8000_0005, "t2_vec5");
    wr(OFF_E, 32'h0);

    // Masked source pends silently until unmasked.
    wr(OFF_M, 32'h04);
    irq_in[2] = 1'b1;
    tick();
    repeat (SL) tick();
    tick();
    rd(OFF_P, 32'h04, "t3_pend");
    chk_intr(1'b0, "t3_masked");
    irq_in[2] = 1'b0;
    wr(OFF_M, 32'h0);
    chk_intr(1'b0, "t3_unmask_pre");
    chk_intr(1'b1, "t3_unmask");
    ack();
    wr(OFF_E, 32'h0);

    // W1C colliding with a new edge: the set wins.
    wr(OFF_M, 32'hFF);
    irq_in[1] = 1'b1;
    tick();
    irq_in[1] = 1'b0;
    repeat (SL + 1) tick();
    rd(OFF_P, 32'h02, "t4_pend_pre");
    irq_in[1] = 1'b1;
    repeat (SL) tick();
    wr(OFF_P, 32'h02);
    rd(OFF_P, 32'h02, "t4_set_wins");
    irq_in[1] = 1'b0;
    repeat (SL + 1) tick();
    wr(OFF_P, 32'h02);
    rd(OFF_P, 32'h0, "t4_w1c");
    wr(OFF_M, 32'hFFFF_FF00);
    rd(OFF_M, 32'h0, "mask_upper_ignored");

    // Reset while in service with another source pending.
    wr(OFF_M, 32'hFE);
    irq_in[0] = 1'b1;
    tick();
    repeat (SL + 1) tick();
    ack();
    irq_in[0] = 1'b0;
    irq_in[4] = 1'b1;
    tick();
    repeat (SL) tick();
    irq_in[4] = 1'b0;
    rd(OFF_P, 32'h10, "t5_pend");
    rd(OFF_V, 32'h8000_0000, "t5_vec");
    repeat (2) tick();
    reset = 1'b1;
    rd(OFF_P, 32'h0, "t5_dout_in_rst");
    reset = 1'b0;
    chk_intr(1'b0, "t5_rst_intr");
    rd(OFF_P, 32'h0, "t5_rst_pend");
    rd(OFF_M, 32'hFF, "t5_rst_mask");
    rd(OFF_V, 32'h0, "t5_rst_vec");
    wr(OFF_E, 32'h0);
    ack();
    rd(OFF_V, 32'h0, "t5_vec_after");
    chk_intr(1'b0, "t5_intr_after");

    done = 1'b1;
    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
